// File: rtl/serial_mag_cmp.sv
// rtl/serial_mag_cmp.sv - bit-serial MSB-first magnitude comparator with word framing
//
// Purpose:
//   Scans two operands one bit pair per accepted cycle, MSB first. The result
//   is decided by the first bit position where the operands differ. When the
//   WIDTH-th bit has been accepted, gt/eq/lt are updated and done pulses for
//   one cycle. With SIGNED=1 the MSB is treated as a sign bit. This is done
//   by swapping the winner when the first bits differ.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a new word (aborts a word in progress, no done for it)
//   bit_valid  x/y carry a valid bit pair this cycle
//   x, y       serial operand bits, MSB first
//   busy       a word is in progress
//   done       one-cycle pulse when a word completes
//   gt/eq/lt   result of the last completed word, held until the next done
//   bit_count  bits accepted so far in the current word (0..WIDTH-1)

module serial_mag_cmp #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     bit_valid,
    input  logic                     x,
    input  logic                     y,
    output logic                     busy,
    output logic                     done,
    output logic                     gt,
    output logic                     eq,
    output logic                     lt,
    output logic [$clog2(WIDTH)-1:0] bit_count
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        EQ_SO_FAR = 2'd0,
        X_GREATER = 2'd1,
        Y_GREATER = 2'd2
    } state_t;

    state_t state;

    // A start restarts the word in the same cycle. The decision logic
    // therefore sees a fresh EQ_SO_FAR state at count 0, so a bit pair that
    // arrives together with start is taken as the MSB.
    state_t        cur_state;
    logic [CW-1:0] cur_count;
    logic          accept;
    logic          first_bit;
    logic          last_bit;
    state_t        next_state;

    always_comb begin
        cur_state  = start ? EQ_SO_FAR : state;
        cur_count  = start ? '0 : bit_count;
        accept     = bit_valid && (busy || start);
        first_bit  = (cur_count == '0);
        last_bit   = (cur_count == LAST_IDX);
        next_state = cur_state;
        if (cur_state == EQ_SO_FAR && x != y) begin
            // In two's complement a set MSB means negative. On the sign bit,
            // the operand holding the 1 is therefore the smaller one.
            if (SIGNED && first_bit) begin
                next_state = x ? Y_GREATER : X_GREATER;
            end else begin
                next_state = x ? X_GREATER : Y_GREATER;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EQ_SO_FAR;
            busy      <= 1'b0;
            done      <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            bit_count <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy      <= 1'b1;
                state     <= EQ_SO_FAR;
                bit_count <= '0;
            end
            if (accept) begin
                if (last_bit) begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    bit_count <= '0;
                    state     <= EQ_SO_FAR;
                    gt        <= (next_state == X_GREATER);
                    eq        <= (next_state == EQ_SO_FAR);
                    lt        <= (next_state == Y_GREATER);
                end else begin
                    state     <= next_state;
                    bit_count <= cur_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_mag_cmp.sv
// tb/tb_serial_mag_cmp.sv - scoreboard bench for serial_mag_cmp (unsigned and signed instances)

module tb_serial_mag_cmp;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic clk = 1'b0;
    logic rst_n;
    logic start, bit_valid, x, y;

    logic busy_u, done_u, gt_u, eq_u, lt_u;
    logic busy_s, done_s, gt_s, eq_s, lt_s;
    logic [CW-1:0] cnt_u, cnt_s;

    int errors = 0;
    int checks = 0;
    int done_cnt_u = 0;
    int done_cnt_s = 0;
    int pushed = 0;

    logic [2:0] q_u[$];
    logic [2:0] q_s[$];
    logic [2:0] last_u, last_s;

    always #5 clk = ~clk;

    serial_mag_cmp #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
        .x(x), .y(y), .busy(busy_u), .done(done_u),
        .gt(gt_u), .eq(eq_u), .lt(lt_u), .bit_count(cnt_u)
    );

    serial_mag_cmp #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
        .x(x), .y(y), .busy(busy_s), .done(done_s),
        .gt(gt_s), .eq(eq_s), .lt(lt_s), .bit_count(cnt_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer comparison, result as {gt,eq,lt}
    function automatic logic [2:0] ref_u(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a > b)  return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [2:0] ref_s(input logic [W-1:0] a, input logic [W-1:0] b);
        if ($signed(a) > $signed(b))  return 3'b100;
        if ($signed(a) == $signed(b)) return 3'b010;
        return 3'b001;
    endfunction

    // Monitor: pops the scoreboard whenever a DUT presents done
    always @(negedge clk) begin
        if (done_u) begin
            done_cnt_u++;
            if (q_u.size() == 0) check("unexpected done_u", 1, 0);
            else check("result_u", {gt_u, eq_u, lt_u}, q_u.pop_front());
        end
        if (done_s) begin
            done_cnt_s++;
            if (q_s.size() == 0) check("unexpected done_s", 1, 0);
            else check("result_s", {gt_s, eq_s, lt_s}, q_s.pop_front());
        end
    end

    task automatic idle(input int n);
        start = 1'b0;
        bit_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends nbits of a word MSB first, start on the first bit. Gaps of glen
    // cycles follow accepted bit numbers ga and gb, or random gaps if rnd.
    task automatic send_word(input logic [W-1:0] xv, input logic [W-1:0] yv,
                             input int nbits, input int ga, input int gb,
                             input int glen, input bit rnd);
        int n;
        for (int i = 0; i < nbits; i++) begin
            start = (i == 0);
            bit_valid = 1'b1;
            x = xv[W-1-i];
            y = yv[W-1-i];
            if (i == W-1) begin
                last_u = ref_u(xv, yv);
                last_s = ref_s(xv, yv);
                q_u.push_back(last_u);
                q_s.push_back(last_s);
                pushed++;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i == W-1) begin
                check("done_u at last edge", done_u, 1);
                check("done_s at last edge", done_s, 1);
                check("busy_u after word", busy_u, 0);
                check("bit_count_u after word", cnt_u, 0);
            end else if (i + 1 == ga || i + 1 == gb || (rnd && $urandom_range(3) == 0)) begin
                bit_valid = 1'b0;
                n = rnd ? int'($urandom_range(1, 3)) : glen;
                repeat (n) begin
                    @(posedge clk);
                    #1;
                end
                check("bit_count_u held in gap", cnt_u, i + 1);
                check("busy_s held in gap", busy_s, 1);
            end
        end
    endtask

    initial begin
        int d0;
        logic [W-1:0] rx, ry;
        rst_n = 1'b0;
        start = 1'b0;
        bit_valid = 1'b0;
        x = 1'b0;
        y = 1'b0;
        last_u = 3'b000;
        last_s = 3'b000;
        idle(2);
        check("reset flags_u", {busy_u, done_u, gt_u, eq_u, lt_u}, 0);
        check("reset bit_count_u", cnt_u, 0);
        check("reset flags_s", {busy_s, done_s, gt_s, eq_s, lt_s}, 0);
        rst_n = 1'b1;
        idle(2);

        // Unsigned basic: A5 > A3
        send_word(8'hA5, 8'hA3, W, 0, 0, 0, 0);
        idle(2);

        // Equal with gaps after bits 2 and 5
        send_word(8'h3C, 8'h3C, W, 2, 5, 2, 0);
        idle(1);
        check("bit_count_s after eq word", cnt_s, 0);

        // Signed pair, back-to-back with start during done
        send_word(8'h80, 8'h01, W, 0, 0, 0, 0);
        send_word(8'h7F, 8'hFF, W, 0, 0, 0, 0);
        idle(2);

        // Abort after 4 bits, then a full word
        d0 = done_cnt_u;
        send_word(8'hFF, 8'h00, 4, 0, 0, 0, 0);
        send_word(8'h10, 8'h20, W, 0, 0, 0, 0);
        idle(2);
        check("single done after abort", done_cnt_u - d0, 1);

        // Stray valid with busy=0 and no start
        d0 = done_cnt_u;
        start = 1'b0;
        bit_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x = $urandom_range(1);
            y = $urandom_range(1);
            @(posedge clk);
            #1;
        end
        bit_valid = 1'b0;
        check("stray busy_u", busy_u, 0);
        check("stray bit_count_u", cnt_u, 0);
        check("stray flags_u", {gt_u, eq_u, lt_u}, last_u);
        check("stray flags_s", {gt_s, eq_s, lt_s}, last_s);
        check("stray no done", done_cnt_u - d0, 0);

        // Asynchronous reset mid-word
        d0 = done_cnt_u;
        send_word(8'h5A, 8'h12, 3, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midword reset flags_u", {busy_u, done_u, gt_u, eq_u, lt_u}, 0);
        check("midword reset bit_count_u", cnt_u, 0);
        check("midword reset flags_s", {busy_s, done_s, gt_s, eq_s, lt_s, cnt_s}, 0);
        idle(2);
        rst_n = 1'b1;
        idle(W + 2);
        check("no done after reset", done_cnt_u - d0, 0);
        last_u = 3'b000;
        last_s = 3'b000;

        // Randomized words: random gaps, aborts and back-to-back
        for (int k = 0; k < 40; k++) begin
            rx = $urandom;
            ry = ($urandom_range(4) == 0) ? rx : W'($urandom);
            if ($urandom_range(7) == 0)
                send_word(rx, ry, int'($urandom_range(1, W-1)), 0, 0, 0, 1);
            else
                send_word(rx, ry, W, 0, 0, 0, 1);
            if ($urandom_range(1) == 0) idle(int'($urandom_range(0, 2)));
        end
        idle(3);

        check("scoreboard_u drained", q_u.size(), 0);
        check("scoreboard_s drained", q_s.size(), 0);
        check("done count_u", done_cnt_u, pushed);
        check("done count_s", done_cnt_s, pushed);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
